wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; select width is DW/8.
REQ-003 Parameter TIMEOUT, default 255, stalled-cycle limit before a bus error; legal range 1..65535.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 mN_adr_i/mN_dat_i/mN_sel_i  in  AW/DW/DW/8  master N (N=0,1) address, write data, byte selects.
REQ-007 mN_we_i/mN_cyc_i/mN_stb_i  in  1 each  master N write enable, cycle, strobe.
REQ-008 mN_cti_i/mN_bte_i  in  3/2  master N burst cycle type, burst type.
REQ-009 mN_dat_o  out  DW  read data to master N.
REQ-010 mN_ack_o/mN_err_o/mN_rty_o  out  1 each  terminations to master N.
REQ-011 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o  out  AW/DW/DW/8/1/1/1/3/2  shared slave port.
REQ-012 s_dat_i/s_ack_i/s_err_i/s_rty_i  in  DW/1/1/1  slave read data and terminations.
REQ-013 grant_o  out  2  one-hot current owner; 2'b00 when idle.
REQ-014 timeout_o  out  1  single-cycle pulse when the watchdog fires.

Function
REQ-015 FSM states IDLE, GNT0, GNT1, registered; grant_o is 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
REQ-016 Register last_gnt records the master most recently granted; it selects the loser of a tie.
REQ-017 IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> the master other than last_gnt; neither -> stay IDLE.
REQ-018 Arbitration latency: one cycle from mN_cyc_i rising in IDLE to s_cyc_o rising.
REQ-019 GNTn: hold while mN_cyc_i=1, regardless of stb, cti, or the other master; no preemption, so bursts and back-to-back accesses stay atomic.
REQ-020 GNTn with mN_cyc_i=0: other master's cyc=1 -> go directly to GNT(other) with no IDLE cycle; otherwise -> IDLE.
REQ-021 last_gnt updates on every entry to GNT0/GNT1.
REQ-022 Slave port is a combinational mux of the granted master's inputs; s_cyc_o = granted cyc, s_stb_o = granted stb.
REQ-023 In IDLE, s_cyc_o, s_stb_o, and s_we_o are 0; s_adr_o, s_dat_o, s_sel_o, s_cti_o, and s_bte_o are 0.
REQ-024 mN_dat_o = s_dat_i for both masters at all times.
REQ-025 mN_ack_o/mN_rty_o = s_ack_i/s_rty_i gated by grant N, same cycle with no register stage.
REQ-026 mN_err_o = (s_err_i | wd_fire) gated by grant N.
REQ-027 The ungranted master sees ack=err=rty=0 and waits.
REQ-028 Watchdog counter, 16 bits, clears when s_cyc_o&s_stb_o=0 or when any of s_ack_i/s_err_i/s_rty_i=1; otherwise it increments.
REQ-029 wd_fire is asserted when counter==TIMEOUT-1 while stalled; the counter then clears, and timeout_o pulses for that cycle.
REQ-030 Watchdog error does not release the grant; the master decides by dropping cyc.
REQ-031 Simultaneous s_ack_i and wd_fire: ack is delivered and wd_fire is suppressed.
REQ-032 A termination arriving in the same cycle cyc drops is ignored; the FSM follows REQ-020.

Reset
REQ-033 wb_rst_i=1 at any edge: state=IDLE, last_gnt=1 (m0 wins the first tie), watchdog=0, timeout_o=0.
REQ-034 During and after reset, all slave-port outputs and all master terminations are 0, including reset mid-burst; the in-flight transaction is abandoned with no termination.
REQ-035 First arbitration occurs on the first edge with wb_rst_i=0.

Verification
REQ-036 Reset release, both cyc rise together -> grant_o=01 next cycle; m0 completes 1 ack; m0 drops cyc -> grant_o=10 on the following edge with no IDLE.
REQ-037 m1 holds cyc for a 4-beat incrementing burst (cti 010,010,010,111) while m0 requests -> all 4 acks reach m1 only; m0 is granted after m1 drops cyc.
REQ-038 Alternating contention, 6 transactions with both requesting -> grant sequence 0,1,0,1,0,1.
REQ-039 TIMEOUT=8, slave never acks -> mN_err_o and timeout_o high exactly on the 8th stalled cycle, low otherwise; counter restarts.
REQ-040 Assert wb_rst_i during GNT1 mid-burst -> next edge: grant_o=00, s_cyc_o=0, no ack/err to m1; after release, m0 wins the first tie.
REQ-041 Read through m0 with s_dat_i=32'hDEADBEEF and ack -> m0_dat_o=32'hDEADBEEF and m0_ack_o=1 in the same cycle; m1_ack_o=0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with a stalled-cycle watchdog.
// The shared slave port is a combinational mux of the current owner, so the
// slave sees the owner's request and the owner sees the slave's termination
// in the same cycle.
module wb_rr_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  // master 0
  input  logic [AW-1:0]        m0_adr_i,
  input  logic [DW-1:0]        m0_dat_i,
  input  logic [DW/8-1:0]      m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  output logic [DW-1:0]        m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,
  // master 1
  input  logic [AW-1:0]        m1_adr_i,
  input  logic [DW-1:0]        m1_dat_i,
  input  logic [DW/8-1:0]      m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  output logic [DW-1:0]        m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,
  // shared slave port
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  // status
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam int unsigned WDW = 16;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last_gnt;   // 0: m0 granted last, 1: m1 granted last
  logic [WDW-1:0] r_wd_cnt;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_stall;
  logic           w_wd_fire;

  // State register and last-owner tracking, updated on each grant entry
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_GNT0 && r_state != ST_GNT0) r_last_gnt <= 1'b0;
      if (w_state_nxt == ST_GNT1 && r_state != ST_GNT1) r_last_gnt <= 1'b1;
    end
  end

  // Next-state: hold while the owner keeps cyc, hand over directly on release
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_state_nxt = r_last_gnt ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        w_state_nxt = ST_GNT0;
        else if (m1_cyc_i)        w_state_nxt = ST_GNT1;
        else                      w_state_nxt = ST_IDLE;
      end
      ST_GNT0: begin
        if (!m0_cyc_i) w_state_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        if (!m1_cyc_i) w_state_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grants are forced off while reset is held so nothing leaks mid-reset
  assign w_gnt0  = (r_state == ST_GNT0) && !wb_rst_i;
  assign w_gnt1  = (r_state == ST_GNT1) && !wb_rst_i;
  assign grant_o = {r_state == ST_GNT1, r_state == ST_GNT0};

  // Slave-port mux of the owner's request; all zero when nobody owns the bus
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    if (w_gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (w_gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  // A real slave termination always wins over the watchdog
  assign w_stall   = s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
  assign w_wd_fire = w_stall && (r_wd_cnt == WD_LIMIT);
  assign timeout_o = w_wd_fire;

  // Watchdog counts consecutive stalled cycles and restarts after firing
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !w_stall || w_wd_fire) r_wd_cnt <= '0;
    else                                   r_wd_cnt <= WDW'(r_wd_cnt + 1'b1);
  end

  // Terminations reach only the owner, and only while its cycle is still open
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_gnt0 && m0_cyc_i && s_ack_i;
  assign m0_rty_o = w_gnt0 && m0_cyc_i && s_rty_i;
  assign m0_err_o = w_gnt0 && m0_cyc_i && (s_err_i || w_wd_fire);
  assign m1_ack_o = w_gnt1 && m1_cyc_i && s_ack_i;
  assign m1_rty_o = w_gnt1 && m1_cyc_i && s_rty_i;
  assign m1_err_o = w_gnt1 && m1_cyc_i && (s_err_i || w_wd_fire);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: arbitration, bursts, watchdog and reset.
module tb_wb_rr_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0] cti_seq [4];
    logic       owner;
    logic       exp_err;
    cti_seq = '{3'b010, 3'b010, 3'b010, 3'b111};

    wb_rst_i = 1'b1;
    m0_adr_i = 32'h0000_1000; m0_dat_i = 32'h0A0A_0A0A; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m1_adr_i = 32'h0000_2000; m1_dat_i = 32'h0B0B_0B0B; m1_sel_i = 4'h3; m1_we_i = 1'b1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000; m0_bte_i = 2'b00;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'b000; m1_bte_i = 2'b00;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // Reset state, with a request and a termination applied during reset
    tick(); tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; #1;
    chk("rst_grant", 64'(grant_o), 64'(2'b00));
    chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_m0_ack", 64'(m0_ack_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    tick();
    chk("rst_grant_hold", 64'(grant_o), 64'(2'b00));

    // Release reset with both masters requesting: m0 wins the first tie
    wb_rst_i = 1'b0; s_ack_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; #1;
    chk("arb_cycle_grant", 64'(grant_o), 64'(2'b00));
    chk("arb_cycle_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("idle_s_adr", 64'(s_adr_o), 64'(0));
    chk("idle_s_we", 64'(s_we_o), 64'(0));
    tick();
    chk("tie_grant_m0", 64'(grant_o), 64'(2'b01));
    chk("m0_s_cyc", 64'(s_cyc_o), 64'(1));
    chk("m0_s_adr", 64'(s_adr_o), 64'(32'h0000_1000));
    chk("m0_s_sel", 64'(s_sel_o), 64'(4'hF));

    // Read completes with data and ack in the same cycle
    s_dat_i = 32'hDEADBEEF; s_ack_i = 1'b1; #1;
    chk("rd_m0_dat", 64'(m0_dat_o), 64'(32'hDEADBEEF));
    chk("rd_m0_ack", 64'(m0_ack_o), 64'(1));
    chk("rd_m1_ack", 64'(m1_ack_o), 64'(0));
    tick();

    // m0 releases; ownership moves to m1 with no idle cycle
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #1;
    chk("drop_grant_held", 64'(grant_o), 64'(2'b01));
    chk("drop_s_cyc", 64'(s_cyc_o), 64'(0));
    tick();
    chk("handover_m1", 64'(grant_o), 64'(2'b10));
    chk("m1_s_adr", 64'(s_adr_o), 64'(32'h0000_2000));
    chk("m1_s_we", 64'(s_we_o), 64'(1));

    // m1 incrementing burst while m0 requests: all acks go to m1
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m1_cti_i = cti_seq[b]; s_ack_i = 1'b1; #1;
      chk("burst_grant", 64'(grant_o), 64'(2'b10));
      chk("burst_s_cti", 64'(s_cti_o), 64'(cti_seq[b]));
      chk("burst_m1_ack", 64'(m1_ack_o), 64'(1));
      chk("burst_m0_ack", 64'(m0_ack_o), 64'(0));
      tick();
    end
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'b000; #1;
    chk("burst_end_grant", 64'(grant_o), 64'(2'b10));
    tick();
    chk("after_burst_m0", 64'(grant_o), 64'(2'b01));

    // Alternating contention: 6 transactions, owners 0,1,0,1,0,1
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      owner = 1'(k % 2);
      s_ack_i = 1'b1; #1;
      chk("alt_grant", 64'(grant_o), owner ? 64'(2'b10) : 64'(2'b01));
      chk("alt_owner_ack", owner ? 64'(m1_ack_o) : 64'(m0_ack_o), 64'(1));
      chk("alt_other_ack", owner ? 64'(m0_ack_o) : 64'(m1_ack_o), 64'(0));
      tick();
      s_ack_i = 1'b0;
      if (owner) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      else       begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      tick();
      if (owner) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
      else       begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("alt_idle", 64'(grant_o), 64'(2'b00));

    // Watchdog: fires on stalled cycles 8 and 16; an ack on the 24th wins
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    for (int s = 1; s <= 24; s++) begin
      s_ack_i = (s == 24); #1;
      exp_err = (s == 8) || (s == 16);
      chk("wd_m0_err", 64'(m0_err_o), 64'(exp_err));
      chk("wd_timeout", 64'(timeout_o), 64'(exp_err));
      chk("wd_m0_ack", 64'(m0_ack_o), 64'(s == 24));
      chk("wd_m1_err", 64'(m1_err_o), 64'(0));
      tick();
    end
    s_ack_i = 1'b0; #1;
    chk("wd_grant_kept", 64'(grant_o), 64'(2'b01));
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    chk("wd_release_idle", 64'(grant_o), 64'(2'b00));

    // Reset during an m1 burst abandons it without any termination
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010;
    tick();
    chk("mid_grant_m1", 64'(grant_o), 64'(2'b10));
    s_ack_i = 1'b1; #1;
    chk("mid_beat_ack", 64'(m1_ack_o), 64'(1));
    tick();
    wb_rst_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1; #1;
    chk("mid_rst_m1_ack", 64'(m1_ack_o), 64'(0));
    chk("mid_rst_m1_err", 64'(m1_err_o), 64'(0));
    chk("mid_rst_s_cyc", 64'(s_cyc_o), 64'(0));
    tick();
    chk("mid_rst_grant", 64'(grant_o), 64'(2'b00));
    chk("mid_rst_s_stb", 64'(s_stb_o), 64'(0));
    wb_rst_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; #1;
    chk("post_rst_idle", 64'(grant_o), 64'(2'b00));
    tick();
    chk("post_rst_tie_m0", 64'(grant_o), 64'(2'b01));

    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
